// File: rtl/mac_bank_seq.sv
// Bank of NUM_CH saturating multiply-accumulate channels with a frame sequencer.
// The bias is preloaded at start, DEPTH products are accumulated, and the result is held until handshaked.
module mac_bank_seq #(
    parameter int unsigned NUM_CH     = 10,
    parameter int unsigned IN_W       = 8,
    parameter int unsigned WT_W       = 8,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FRAC_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      bias_we,
    input  logic [NUM_CH*ACC_W-1:0]   bias_in,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           act_in,
    input  logic [NUM_CH*WT_W-1:0]    wt_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*OUT_W-1:0]   sum_out,
    output logic [NUM_CH-1:0]         ovf,
    output logic                      busy
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PROD_W = WT_W + IN_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      prod_v_q, prod_v_d;
    logic [NUM_CH*ACC_W-1:0]   bias_q, bias_d;
    logic [NUM_CH-1:0]         ovf_q, ovf_d;
    logic [NUM_CH*OUT_W-1:0]   sum_q, sum_d;
    logic                      in_ready_q, in_ready_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic signed [ACC_W-1:0]   acc_q  [NUM_CH];
    logic signed [ACC_W-1:0]   acc_d  [NUM_CH];
    logic signed [ACC_W-1:0]   prod_q [NUM_CH];
    logic signed [ACC_W-1:0]   prod_d [NUM_CH];

    // Signed weight times zero-extended activation, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [WT_W-1:0] w,
                                                        input logic [IN_W-1:0] a);
        logic signed [PROD_W-1:0] p;
        p = $signed(PROD_W'(w)) * $signed(PROD_W'($signed({1'b0, a})));
        return ACC_W'(p);
    endfunction

    // Returns {overflow, clamped sum}.
    function automatic logic [ACC_W:0] add_sat(input logic signed [ACC_W-1:0] a,
                                               input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    // Returns {clamped, scaled output}.
    function automatic logic [OUT_W:0] out_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> FRAC_SHIFT;
        if (sh > OUT_MAX) begin
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        end
        if (sh < OUT_MIN) begin
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        end
        return {1'b0, sh[OUT_W-1:0]};
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin : p_next
        logic [ACC_W:0] add_r;
        logic [OUT_W:0] out_r;

        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_v_d = 1'b0;
        bias_d   = bias_we ? bias_in : bias_q;
        ovf_d    = ovf_q;
        sum_d    = '0;
        add_r    = '0;
        out_r    = '0;
        for (int unsigned m = 0; m < NUM_CH; m++) begin
            acc_d[m]  = acc_q[m];
            prod_d[m] = prod_q[m];
        end

        // The product registered last cycle is folded in regardless of state.
        if (prod_v_q) begin
            for (int unsigned m = 0; m < NUM_CH; m++) begin
                add_r    = add_sat(acc_q[m], prod_q[m]);
                acc_d[m] = add_r[ACC_W-1:0];
                if (add_r[ACC_W]) begin
                    ovf_d[m] = 1'b1;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                    ovf_d   = '0;
                    for (int unsigned m = 0; m < NUM_CH; m++) begin
                        acc_d[m] = bias_q[m*ACC_W +: ACC_W];
                    end
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    prod_v_d = 1'b1;
                    cnt_d    = CNT_W'(cnt_q + 1'b1);
                    for (int unsigned m = 0; m < NUM_CH; m++) begin
                        prod_d[m] = mul_ext(wt_in[m*WT_W +: WT_W], act_in);
                    end
                    if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output clamping only counts while the frame is still being built.
        for (int unsigned m = 0; m < NUM_CH; m++) begin
            out_r = out_sat(acc_d[m]);
            sum_d[m*OUT_W +: OUT_W] = out_r[OUT_W-1:0];
            if (out_r[OUT_W] && (state_q == ST_ACCUM || state_q == ST_DRAIN)) begin
                ovf_d[m] = 1'b1;
            end
        end

        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prod_v_q    <= 1'b0;
            bias_q      <= '0;
            ovf_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int unsigned m = 0; m < NUM_CH; m++) begin
                acc_q[m]  <= '0;
                prod_q[m] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prod_v_q    <= prod_v_d;
            bias_q      <= bias_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int unsigned m = 0; m < NUM_CH; m++) begin
                acc_q[m]  <= acc_d[m];
                prod_q[m] <= prod_d[m];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum_out   = sum_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_bank_seq.sv
// Directed bench for mac_bank_seq: stimulus pushes expected frames, a monitor pops them on each output handshake.
module tb_mac_bank_seq;

    localparam int unsigned NUM_CH = 10;
    localparam int unsigned IN_W   = 8;
    localparam int unsigned WT_W   = 8;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned OUT_W  = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = NUM_CH * OUT_W;

    typedef logic [CW-1:0] cv_t;
    typedef struct packed {
        logic [NUM_CH*OUT_W-1:0] sum;
        logic [NUM_CH-1:0]       ovf;
    } exp_t;

    logic                     clk, clr, bias_we, start, in_valid, in_ready;
    logic                     out_valid, out_ready, busy;
    logic [NUM_CH*ACC_W-1:0]  bias_in;
    logic [IN_W-1:0]          act_in;
    logic [NUM_CH*WT_W-1:0]   wt_in;
    logic [NUM_CH*OUT_W-1:0]  sum_out;
    logic [NUM_CH-1:0]        ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [NUM_CH*WT_W-1:0]  w_basic, w_sat;
    logic [NUM_CH*ACC_W-1:0] b_five, b_hundred;
    logic [NUM_CH*OUT_W-1:0] s_basic, s_sat, s_race2, s_clr;
    logic [4*IN_W-1:0]       a_basic, a_sat;

    mac_bank_seq #(
        .NUM_CH(NUM_CH), .IN_W(IN_W), .WT_W(WT_W), .ACC_W(ACC_W),
        .OUT_W(OUT_W), .DEPTH(DEPTH), .FRAC_SHIFT(0)
    ) dut (
        .clk(clk), .clr(clr), .bias_we(bias_we), .bias_in(bias_in), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wt_in(wt_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out), .ovf(ovf),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input cv_t act, input cv_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*WT_W-1:0] pack_wt(input int c0, input int c1,
                                                       input int c2, input int c3);
        logic [NUM_CH*WT_W-1:0] r;
        r = '0;
        r[0*WT_W +: WT_W] = WT_W'(c0);
        r[1*WT_W +: WT_W] = WT_W'(c1);
        r[2*WT_W +: WT_W] = WT_W'(c2);
        r[3*WT_W +: WT_W] = WT_W'(c3);
        return r;
    endfunction

    function automatic logic [NUM_CH*OUT_W-1:0] pack_sum(input int c0, input int c1,
                                                         input int c2, input int c3);
        logic [NUM_CH*OUT_W-1:0] r;
        r = '0;
        r[0*OUT_W +: OUT_W] = OUT_W'(c0);
        r[1*OUT_W +: OUT_W] = OUT_W'(c1);
        r[2*OUT_W +: OUT_W] = OUT_W'(c2);
        r[3*OUT_W +: OUT_W] = OUT_W'(c3);
        return r;
    endfunction

    // Present one sample once the bank is ready, then idle for gap cycles.
    task automatic send(input logic [IN_W-1:0] a, input logic [NUM_CH*WT_W-1:0] w, input int gap);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", cv_t'(in_ready), cv_t'(1));
        in_valid = 1'b1;
        act_in   = a;
        wt_in    = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        act_in   = '0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    // One full frame; hold > 0 keeps out_ready low that many OUT cycles while pulsing start.
    task automatic frame(input logic [4*IN_W-1:0] acts, input logic [NUM_CH*WT_W-1:0] w,
                         input int gap, input logic [NUM_CH*OUT_W-1:0] es,
                         input logic [NUM_CH-1:0] eo, input int hold,
                         input logic race, input logic [NUM_CH*ACC_W-1:0] rbias);
        exp_t e;
        e.sum = es;
        e.ovf = eo;
        exp_q.push_back(e);
        out_ready = (hold == 0);
        start = 1'b1;
        if (race) begin
            bias_we = 1'b1;
            bias_in = rbias;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        bias_we = 1'b0;
        check("busy_after_start", cv_t'(busy), cv_t'(1));
        check("in_ready_after_start", cv_t'(in_ready), cv_t'(1));
        for (int i = 0; i < int'(DEPTH); i++) begin
            send(acts[i*IN_W +: IN_W], w, (i == int'(DEPTH) - 1) ? 0 : gap);
        end
        check("drain_in_ready", cv_t'(in_ready), cv_t'(0));
        check("drain_out_valid", cv_t'(out_valid), cv_t'(0));
        @(posedge clk); #1;
        check("out_valid_rise", cv_t'(out_valid), cv_t'(1));
        for (int i = 0; i < hold; i++) begin
            check("hold_out_valid", cv_t'(out_valid), cv_t'(1));
            check("hold_busy", cv_t'(busy), cv_t'(1));
            check("hold_sum", cv_t'(sum_out), cv_t'(es));
            check("hold_ovf", cv_t'(ovf), cv_t'(eo));
            start = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_out_valid", cv_t'(out_valid), cv_t'(0));
        check("idle_busy", cv_t'(busy), cv_t'(0));
    endtask

    // Scoreboard monitor: compares on every output handshake.
    always @(negedge clk) begin
        if (clr === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", sum_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum_out", cv_t'(sum_out), cv_t'(mon_e.sum));
                check("ovf", cv_t'(ovf), cv_t'(mon_e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        w_basic   = pack_wt(-3, 1, 0, 0);
        w_sat     = pack_wt(0, 0, 127, -128);
        b_five    = '0;
        b_five[0 +: ACC_W]    = ACC_W'(5);
        b_hundred = '0;
        b_hundred[0 +: ACC_W] = ACC_W'(100);
        s_basic   = pack_sum(-55, 20, 0, 0);
        s_sat     = pack_sum(5, 0, 32767, -32768);
        s_race2   = pack_sum(40, 20, 0, 0);
        s_clr     = pack_sum(-60, 20, 0, 0);
        a_basic   = {8'd8, 8'd6, 8'd4, 8'd2};
        a_sat     = {8'd255, 8'd255, 8'd255, 8'd255};

        clr = 1'b1; bias_we = 1'b0; bias_in = '0; start = 1'b0; in_valid = 1'b0;
        act_in = '0; wt_in = '0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", cv_t'(in_ready), cv_t'(0));
        check("rst_out_valid", cv_t'(out_valid), cv_t'(0));
        check("rst_busy", cv_t'(busy), cv_t'(0));
        check("rst_sum_out", cv_t'(sum_out), cv_t'(0));
        check("rst_ovf", cv_t'(ovf), cv_t'(0));
        @(posedge clk); #1;
        clr = 1'b0;
        bias_we = 1'b1;
        bias_in = b_five;
        @(posedge clk); #1;
        bias_we = 1'b0;

        frame(a_basic, w_basic, 0, s_basic, '0, 0, 1'b0, '0);
        frame(a_basic, w_basic, 3, s_basic, '0, 0, 1'b0, '0);
        frame(a_sat, w_sat, 0, s_sat, 10'b00_0000_1100, 0, 1'b0, '0);
        frame(a_basic, w_basic, 0, s_basic, '0, 5, 1'b0, '0);
        frame(a_basic, w_basic, 0, s_basic, '0, 0, 1'b1, b_hundred);
        frame(a_basic, w_basic, 1, s_race2, '0, 0, 1'b0, '0);

        // Abort a frame after two accepts with an asynchronous clear.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send(8'd2, w_basic, 0);
        send(8'd4, w_basic, 0);
        clr = 1'b1;
        #1;
        check("clr_in_ready", cv_t'(in_ready), cv_t'(0));
        check("clr_out_valid", cv_t'(out_valid), cv_t'(0));
        check("clr_busy", cv_t'(busy), cv_t'(0));
        check("clr_sum_out", cv_t'(sum_out), cv_t'(0));
        check("clr_ovf", cv_t'(ovf), cv_t'(0));
        #4;
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        frame(a_basic, w_basic, 0, s_clr, '0, 0, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", cv_t'(exp_q.size()), cv_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
